countdown_timer_mmss: RTL and testbench



---
 rtl/countdown_timer_mmss.sv | 208 ++++++++++++++++++++
 tb/tb_countdown_timer_mmss.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer_mmss.sv
// mm:ss countdown timer (up to 99:59) with DONE alarm and registered BCD digits.
// Optional macro AUTO_REPEAT_EN adds hold-to-repeat on the add/sub buttons.
module countdown_timer_mmss #(
  parameter int CLK_HZ         = 10_000_000,
  parameter int MAX_SEC        = 5999,
  parameter int PRESET_SEC     = 60,
  parameter int STEP_SEC       = 1,
  parameter int ALARM_SEC      = 3,
  parameter int REPEAT_DLY_CYC = 5_000_000,
  parameter int REPEAT_PER_CYC = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_pause_p,
  input  logic       reset_p,
  input  logic       add_p,
  input  logic       sub_p,
  input  logic       add_hold,
  input  logic       sub_hold,
  output logic [3:0] bcd_min_tens,
  output logic [3:0] bcd_min_ones,
  output logic [3:0] bcd_sec_tens,
  output logic [3:0] bcd_sec_ones,
  output logic       running,
  output logic       expired,
  output logic       alarm
);
  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int AW = (ALARM_SEC > 1) ? $clog2(ALARM_SEC) : 1;

  if (MAX_SEC > 5999 || MAX_SEC < 1) begin : g_bad_max
    $error("MAX_SEC must be in 1..5999");
  end
  if (PRESET_SEC > MAX_SEC) begin : g_bad_preset
    $error("PRESET_SEC exceeds MAX_SEC");
  end
  if (STEP_SEC == 0) begin : g_bad_step
    $error("STEP_SEC must be non-zero");
  end
  if (ALARM_SEC < 1 || REPEAT_DLY_CYC < 1 || REPEAT_PER_CYC < 1) begin : g_bad_dur
    $error("ALARM_SEC and repeat timings must be at least 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  function automatic logic [15:0] to_bcd(input logic [12:0] s);
    logic [6:0] m;
    logic [5:0] ss;
    m  = 7'(s / 13'd60);
    ss = 6'(s % 13'd60);
    return {4'(m / 7'd10), 4'(m % 7'd10), 4'(ss / 6'd10), 4'(ss % 6'd10)};
  endfunction

  localparam logic [15:0] BCD_RST = to_bcd(13'(PRESET_SEC));

  state_t          r_state;
  logic [12:0]     r_rem, r_set;
  logic [PW-1:0]   r_presc;
  logic [AW-1:0]   r_alarm_cnt;
  logic [15:0]     r_bcd;
  logic            r_running, r_expired, r_alarm;

  logic            w_tick, w_add, w_sub, w_edit;
  logic [13:0]     w_sum;
  logic [12:0]     w_add_val, w_sub_val, w_edit_val;

  assign w_tick     = (r_presc == PW'(CLK_HZ - 1));
  assign w_sum      = {1'b0, r_rem} + 14'(STEP_SEC);
  assign w_add_val  = (w_sum > 14'(MAX_SEC)) ? 13'(MAX_SEC) : w_sum[12:0];
  assign w_sub_val  = (r_rem > 13'(STEP_SEC)) ? (r_rem - 13'(STEP_SEC)) : '0;
  // Opposing add and sub in the same cycle cancel out.
  assign w_edit     = w_add ^ w_sub;
  assign w_edit_val = w_add ? w_add_val : w_sub_val;

`ifdef AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DLY_CYC > REPEAT_PER_CYC) ? REPEAT_DLY_CYC : REPEAT_PER_CYC;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0] r_rep_cnt;
  logic          r_rep_on;
  state_t        r_rep_st;
  logic          w_hold_ok, w_rep_fire;

  // Any state change shows up as r_rep_st != r_state and restarts the hold timer.
  assign w_hold_ok  = (add_hold ^ sub_hold) && (r_state == r_rep_st) &&
                      (r_state == S_IDLE || r_state == S_PAUSE);
  assign w_rep_fire = w_hold_ok && (r_rep_on ? (r_rep_cnt == RW'(REPEAT_PER_CYC))
                                             : (r_rep_cnt == RW'(REPEAT_DLY_CYC)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rep_cnt <= '0;
      r_rep_on  <= 1'b0;
      r_rep_st  <= S_IDLE;
    end else begin
      r_rep_st <= r_state;
      if (!w_hold_ok) begin
        r_rep_cnt <= '0;
        r_rep_on  <= 1'b0;
      end else if (w_rep_fire) begin
        r_rep_cnt <= RW'(1);
        r_rep_on  <= 1'b1;
      end else begin
        r_rep_cnt <= r_rep_cnt + RW'(1);
      end
    end
  end

  assign w_add = add_p | (w_rep_fire & add_hold);
  assign w_sub = sub_p | (w_rep_fire & sub_hold);
`else
  logic w_unused_hold;
  assign w_unused_hold = add_hold ^ sub_hold;
  assign w_add = add_p;
  assign w_sub = sub_p;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rem       <= 13'(PRESET_SEC);
      r_set       <= 13'(PRESET_SEC);
      r_presc     <= '0;
      r_alarm_cnt <= '0;
      r_running   <= 1'b0;
      r_expired   <= 1'b0;
      r_alarm     <= 1'b0;
    end else begin
      r_expired <= 1'b0;
      if (reset_p) begin
        r_state   <= S_IDLE;
        r_rem     <= r_set;
        r_presc   <= '0;
        r_alarm   <= 1'b0;
        r_running <= 1'b0;
      end else if (start_pause_p) begin
        case (r_state)
          S_IDLE: if (r_rem != '0) begin
            r_state   <= S_RUN;
            r_presc   <= '0;
            r_running <= 1'b1;
          end
          S_RUN: begin
            r_state   <= S_PAUSE;
            r_running <= 1'b0;
          end
          S_PAUSE: if (r_rem == '0) begin
            r_state     <= S_DONE;
            r_expired   <= 1'b1;
            r_alarm     <= 1'b1;
            r_alarm_cnt <= '0;
            r_presc     <= '0;
          end else begin
            r_state   <= S_RUN;
            r_running <= 1'b1;
          end
          default: begin
            r_state <= S_IDLE;
            r_rem   <= r_set;
            r_alarm <= 1'b0;
          end
        endcase
      end else begin
        case (r_state)
          S_IDLE: if (w_edit) begin
            r_rem <= w_edit_val;
            r_set <= w_edit_val;
          end
          S_PAUSE: if (w_edit) r_rem <= w_edit_val;
          S_RUN: begin
            if (w_tick) begin
              r_presc <= '0;
              if (r_rem == 13'd1) begin
                r_state     <= S_DONE;
                r_rem       <= '0;
                r_expired   <= 1'b1;
                r_alarm     <= 1'b1;
                r_alarm_cnt <= '0;
                r_running   <= 1'b0;
              end else begin
                r_rem <= r_rem - 13'd1;
              end
            end else begin
              r_presc <= r_presc + PW'(1);
            end
          end
          default: begin
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
            if (w_tick && r_alarm) begin
              if (r_alarm_cnt == AW'(ALARM_SEC - 1)) r_alarm <= 1'b0;
              else                                   r_alarm_cnt <= r_alarm_cnt + AW'(1);
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_bcd <= BCD_RST;
    else     r_bcd <= to_bcd(r_rem);
  end

  assign {bcd_min_tens, bcd_min_ones, bcd_sec_tens, bcd_sec_ones} = r_bcd;
  assign running = r_running;
  assign expired = r_expired;
  assign alarm   = r_alarm;
endmodule

// File: tb/tb_countdown_timer_mmss.sv
// Scoreboard bench for countdown_timer_mmss with a 10-cycle "second".
module tb_countdown_timer_mmss;
  logic clk = 1'b0, rst = 1'b1;
  logic start_pause_p = 0, reset_p = 0, add_p = 0, sub_p = 0, add_hold = 0, sub_hold = 0;
  logic [3:0] bcd_min_tens, bcd_min_ones, bcd_sec_tens, bcd_sec_ones;
  logic running, expired, alarm;

  countdown_timer_mmss #(
    .CLK_HZ(10), .MAX_SEC(5999), .PRESET_SEC(60), .STEP_SEC(1), .ALARM_SEC(3),
    .REPEAT_DLY_CYC(20), .REPEAT_PER_CYC(5)
  ) dut (
    .clk(clk), .rst(rst), .start_pause_p(start_pause_p), .reset_p(reset_p),
    .add_p(add_p), .sub_p(sub_p), .add_hold(add_hold), .sub_hold(sub_hold),
    .bcd_min_tens(bcd_min_tens), .bcd_min_ones(bcd_min_ones),
    .bcd_sec_tens(bcd_sec_tens), .bcd_sec_ones(bcd_sec_ones),
    .running(running), .expired(expired), .alarm(alarm)
  );

  always #5 clk = ~clk;

  // Observation word: {running, alarm, expired, mm:ss digits}, so %h reads as "f_MMSS".
  typedef logic [18:0] obs_t;
  obs_t exp_q[$];
  obs_t e;
  int total = 0, bad = 0;

  function automatic obs_t mk(input int s, input bit r, input bit a, input bit x);
    int m, ss;
    m = s / 60; ss = s % 60;
    return {r, a, x, 4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic obs_t cur();
    return {running, alarm, expired, bcd_min_tens, bcd_min_ones, bcd_sec_tens, bcd_sec_ones};
  endfunction

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    step(2); rst = 1'b0;
    exp_q.push_back(mk(60, 0, 0, 0));
    step(1);
    e = exp_q.pop_front(); total++;
    if (cur() !== e) begin bad++; $display("FAIL reset_state got=%h want=%h", cur(), e); end
    start_pause_p = 1; step(1); start_pause_p = 0;
    exp_q.push_back(mk(59, 1, 0, 0));
    step(15);
    e = exp_q.pop_front(); total++;
    if (cur() !== e) begin bad++; $display("FAIL run_before_rst got=%h want=%h", cur(), e); end
    rst = 1'b1;
    exp_q.push_back(mk(60, 0, 0, 0));
    #1;
    e = exp_q.pop_front(); total++;
    if (cur() !== e) begin bad++; $display("FAIL async_rst_mid_run got=%h want=%h", cur(), e); end
    step(1); rst = 1'b0; step(1);
  endtask

  task automatic test_auto_repeat;
    int r;
    add_p = 1; add_hold = 1; step(1); add_p = 0;
    for (int k = 1; k <= 44; k++) begin
      // Value shown at this sample is remaining after the previous edge (k-1 edges since press).
`ifdef AUTO_REPEAT_EN
      r = (k - 1 < 20) ? 61 : (k - 1 < 25) ? 62 : (k - 1 < 30) ? 63 : (k - 1 < 35) ? 64 : 65;
`else
      r = 61;
`endif
      exp_q.push_back(mk(r, 0, 0, 0));
      step(1);
      e = exp_q.pop_front(); total++;
      if (cur() !== e) begin bad++; $display("FAIL auto_repeat k=%0d got=%h want=%h", k, cur(), e); end
      if (k == 39) add_hold = 0;
    end
  endtask

  task automatic test_countdown;
    int r;
    rst = 1; step(1); rst = 0;
    sub_p = 1; step(57); sub_p = 0;
    exp_q.push_back(mk(3, 0, 0, 0));
    step(1);
    e = exp_q.pop_front(); total++;
    if (cur() !== e) begin bad++; $display("FAIL set_0003 got=%h want=%h", cur(), e); end
    start_pause_p = 1; step(1); start_pause_p = 0;
    for (int k = 1; k <= 65; k++) begin
      r = 3 - (k - 1) / 10;
      if (r < 0) r = 0;
      exp_q.push_back(mk(r, k < 30, (k >= 30) && (k < 60), k == 30));
      step(1);
      e = exp_q.pop_front(); total++;
      if (cur() !== e) begin bad++; $display("FAIL countdown k=%0d got=%h want=%h", k, cur(), e); end
    end
  endtask

  task automatic test_pause;
    start_pause_p = 1; step(1); start_pause_p = 0;
    exp_q.push_back(mk(3, 0, 0, 0));
    step(1);
    e = exp_q.pop_front(); total++;
    if (cur() !== e) begin bad++; $display("FAIL done_to_idle got=%h want=%h", cur(), e); end
    start_pause_p = 1; step(1); start_pause_p = 0;
    step(15);
    start_pause_p = 1; step(1); start_pause_p = 0;
    exp_q.push_back(mk(2, 0, 0, 0));
    step(100);
    e = exp_q.pop_front(); total++;
    if (cur() !== e) begin bad++; $display("FAIL paused_hold got=%h want=%h", cur(), e); end
    start_pause_p = 1; step(1); start_pause_p = 0;
    for (int k = 1; k <= 8; k++) begin
      exp_q.push_back(mk((k <= 5) ? 2 : 1, 1, 0, 0));
      step(1);
      e = exp_q.pop_front(); total++;
      if (cur() !== e) begin bad++; $display("FAIL resume k=%0d got=%h want=%h", k, cur(), e); end
    end
    start_pause_p = 1; step(1); start_pause_p = 0;
    add_p = 1; step(1); add_p = 0;
    exp_q.push_back(mk(2, 0, 0, 0));
    step(1);
    e = exp_q.pop_front(); total++;
    if (cur() !== e) begin bad++; $display("FAIL pause_add got=%h want=%h", cur(), e); end
    reset_p = 1; step(1); reset_p = 0;
    exp_q.push_back(mk(3, 0, 0, 0));
    step(1);
    e = exp_q.pop_front(); total++;
    if (cur() !== e) begin bad++; $display("FAIL reset_p_restore got=%h want=%h", cur(), e); end
  endtask

  task automatic test_saturation;
    add_p = 1; step(6000); add_p = 0;
    exp_q.push_back(mk(5999, 0, 0, 0));
    step(1);
    e = exp_q.pop_front(); total++;
    if (cur() !== e) begin bad++; $display("FAIL reach_9959 got=%h want=%h", cur(), e); end
    add_p = 1; step(1); add_p = 0;
    exp_q.push_back(mk(5999, 0, 0, 0));
    step(1);
    e = exp_q.pop_front(); total++;
    if (cur() !== e) begin bad++; $display("FAIL add_at_max got=%h want=%h", cur(), e); end
    sub_p = 1; step(6000); sub_p = 0;
    exp_q.push_back(mk(0, 0, 0, 0));
    step(1);
    e = exp_q.pop_front(); total++;
    if (cur() !== e) begin bad++; $display("FAIL reach_0000 got=%h want=%h", cur(), e); end
    sub_p = 1; step(1); sub_p = 0;
    exp_q.push_back(mk(0, 0, 0, 0));
    step(1);
    e = exp_q.pop_front(); total++;
    if (cur() !== e) begin bad++; $display("FAIL sub_at_zero got=%h want=%h", cur(), e); end
    add_p = 1; sub_p = 1; step(1); add_p = 0; sub_p = 0;
    exp_q.push_back(mk(0, 0, 0, 0));
    step(1);
    e = exp_q.pop_front(); total++;
    if (cur() !== e) begin bad++; $display("FAIL add_sub_cancel got=%h want=%h", cur(), e); end
    start_pause_p = 1; step(1); start_pause_p = 0;
    exp_q.push_back(mk(0, 0, 0, 0));
    step(1);
    e = exp_q.pop_front(); total++;
    if (cur() !== e) begin bad++; $display("FAIL start_at_zero got=%h want=%h", cur(), e); end
    add_p = 1; step(1); add_p = 0;
    exp_q.push_back(mk(1, 0, 0, 0));
    step(1);
    e = exp_q.pop_front(); total++;
    if (cur() !== e) begin bad++; $display("FAIL still_idle_add got=%h want=%h", cur(), e); end
    // Pause, edit down to zero, then resume straight into DONE.
    start_pause_p = 1; step(1); start_pause_p = 0;
    start_pause_p = 1; step(1); start_pause_p = 0;
    sub_p = 1; step(1); sub_p = 0;
    start_pause_p = 1;
    exp_q.push_back(mk(0, 0, 1, 1));
    step(1); start_pause_p = 0;
    e = exp_q.pop_front(); total++;
    if (cur() !== e) begin bad++; $display("FAIL pause_zero_expire got=%h want=%h", cur(), e); end
    exp_q.push_back(mk(0, 0, 1, 0));
    step(1);
    e = exp_q.pop_front(); total++;
    if (cur() !== e) begin bad++; $display("FAIL expired_one_cycle got=%h want=%h", cur(), e); end
  endtask

  task automatic test_priority;
    start_pause_p = 1;
    exp_q.push_back(mk(0, 0, 0, 0));
    step(1); start_pause_p = 0;
    e = exp_q.pop_front(); total++;
    if (cur() !== e) begin bad++; $display("FAIL done_start_alarm_clr got=%h want=%h", cur(), e); end
    exp_q.push_back(mk(1, 0, 0, 0));
    step(1);
    e = exp_q.pop_front(); total++;
    if (cur() !== e) begin bad++; $display("FAIL done_start_reload got=%h want=%h", cur(), e); end
    add_p = 1; step(4); add_p = 0;
    start_pause_p = 1; step(1); start_pause_p = 0;
    step(12);
    reset_p = 1; start_pause_p = 1;
    exp_q.push_back(mk(4, 0, 0, 0));
    step(1); reset_p = 0; start_pause_p = 0;
    e = exp_q.pop_front(); total++;
    if (cur() !== e) begin bad++; $display("FAIL reset_beats_start got=%h want=%h", cur(), e); end
    exp_q.push_back(mk(5, 0, 0, 0));
    step(1);
    e = exp_q.pop_front(); total++;
    if (cur() !== e) begin bad++; $display("FAIL reset_reload_set got=%h want=%h", cur(), e); end
    start_pause_p = 1; step(1); start_pause_p = 0;
    exp_q.push_back(mk(0, 0, 1, 0));
    step(55);
    e = exp_q.pop_front(); total++;
    if (cur() !== e) begin bad++; $display("FAIL done_alarm_high got=%h want=%h", cur(), e); end
    start_pause_p = 1;
    exp_q.push_back(mk(0, 0, 0, 0));
    step(1); start_pause_p = 0;
    e = exp_q.pop_front(); total++;
    if (cur() !== e) begin bad++; $display("FAIL alarm_cleared got=%h want=%h", cur(), e); end
    exp_q.push_back(mk(5, 0, 0, 0));
    step(1);
    e = exp_q.pop_front(); total++;
    if (cur() !== e) begin bad++; $display("FAIL idle_after_done got=%h want=%h", cur(), e); end
  endtask

  initial begin
    test_reset;
    test_auto_repeat;
    test_countdown;
    test_pause;
    test_saturation;
    test_priority;
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
